main_host_sequencer: RTL and testbench
======================================

// Module: main_host_sequencer
// PURPOSE
// Host-side master for the `main` FrodoKEM core: the transmitting end of its cmd/in ports and the receiving end of its out port.
// Accepts one job descriptor: command, input word count, output word count, byte-swap flag.
// Issues the command, streams input words from a source stream into `main`, and streams `main` output words to a sink.
// Replaces the bench's CMD_SEND/SEND_ARRAY/RECEIVE_ARRAY sequencing in silicon (SoC bridge, FPGA bring-up).
// PARAMETERS
// CMD_W    `MainCMD_SIZE  width of the main command word
// LEN_W    16             width of word counters (max 65535 words; decaps-1344 needs 8206)
// PORTS
// clk              in   1      clock, all logic on posedge
// rst              in   1      asynchronous reset, ACTIVE-LOW (0 = reset)
// job_cmd          in   CMD_W  command to issue to main
// job_inWords      in   LEN_W  number of 64-bit words to feed main.in
// job_outWords     in   LEN_W  number of 64-bit words to collect from main.out
// job_swap         in   1      1: reverse byte order of every word, both directions
// job_isReady      in   1      descriptor valid
// job_canReceive   out  1      descriptor accepted when both high
// src / src_isReady / src_canReceive        in 64 / in 1 / out 1   input data stream from host
// dst / dst_isReady / dst_canReceive        out 64 / out 1 / in 1  output data stream to host
// m_cmd / m_cmd_isReady / m_cmd_canReceive  out CMD_W / out 1 / in 1  to main cmd port
// m_in / m_in_isReady / m_in_canReceive     out 64 / out 1 / in 1  to main in port
// m_out / m_out_isReady / m_out_canReceive  in 64 / in 1 / out 1  from main out port
// busy             out  1      job in progress (CMD or RUN)
// done             out  1      one-cycle pulse when job completes
// BEHAVIOUR
// - Handshake everywhere: a word transfers at the posedge where X_isReady & X_canReceive are both 1.
//   A producer holds data stable while isReady=1 and not accepted; isReady never depends combinationally on canReceive.
// - Reset (rst=0, async): state IDLE, counters 0, both skid buffers empty.
//   All *_isReady outputs 0; src_canReceive, m_out_canReceive, busy, done 0.
//   m_cmd and dst are 0. job_canReceive is 1 once rst=1 and the state is IDLE.
// - FSM IDLE: job_canReceive=1. On job handshake: latch cmd, counts and swap; go to CMD.
// - FSM CMD: m_cmd=latched cmd, m_cmd_isReady=1, held until m_cmd_canReceive. On handshake go to RUN (m_cmd returns to 0).
// - FSM RUN: input and output paths run concurrently, so any ordering main uses cannot deadlock.
//   - input path: src_canReceive=(inCnt!=0) & skid not full; each src accept decrements inCnt.
//   - output path: m_out_canReceive=(outCnt!=0) & skid not full; each accept decrements outCnt.
//   - RUN -> IDLE when inCnt==0, outCnt==0 and both skids are empty. done=1 for that single cycle.
//   - Counts 0/0 (setParam): RUN lasts exactly 1 cycle, then done.
// - Data path: src -> swap -> skid -> m_in; m_out -> swap -> skid -> dst.
//   Swap: out[i*8+:8]=in[(7-i)*8+:8] when swap=1, identity otherwise. Latency 1 cycle (registered). Full throughput: 1 word/cycle.
// - Output stops at the count: after outCnt hits 0, m_out_canReceive stays 0 and extra main words are never consumed.
// - Input stops at the count: after inCnt hits 0, src_canReceive stays 0.
// - No job queueing: a new descriptor is accepted only in IDLE, at the earliest the cycle after done.
// - Reset mid-job: immediate abort. Buffered words are discarded and the state returns to IDLE.
//   The `main` core must be reset alongside it.
// - Counter decrement and skid push/pop on the same cycle are both honoured. Counters never wrap below 0.
// STRUCTURE
// - Shared package/header: FSM state encoding (IDLE/CMD/RUN), swapBytes64 function, LEN_W default.
// - One sub-module, stream_skid64: 2-entry skid buffer, 64-bit, isReady/canReceive both sides.
//   It is instantiated twice (input path and output path).
// TESTING
// - setParam640, counts 0/0: m_cmd_isReady for 1 cycle; done exactly 1 cycle after the cmd handshake; no src/m_out activity.
// - swap=1, src=64'h0102030405060708: m_in=64'h0807060504030201 one cycle later.
//   m_out=64'hAABBCCDDEEFF0011 gives dst=64'h1100FFEEDDCCBBAA.
// - decaps-640 job, inWords=3705, outWords=2, src always ready, m_in_canReceive always 1:
//   3705 m_in transfers in 3705 consecutive cycles, then 2 dst words, then one done pulse.
// - Backpressure: toggle m_in_canReceive and dst_canReceive at pseudo-random.
//   No word lost or duplicated; words stay in order; m_in stable while stalled.
// - Over-supply: main presents a 3rd word with outWords=2. It is never accepted; job ends after 2; busy=0.
// - Reset low mid-RUN (inCnt=100): all isReady outputs 0 immediately; after release job_canReceive=1 and a fresh job runs correctly.

Source files
------------

// File: rtl/main_host_sequencer_pkg.sv
// Shared definitions for the main_host_sequencer slice: FSM states, default
// widths and the 64-bit byte-reversal helper used on both data paths.
package main_host_sequencer_pkg;

    localparam int MAIN_CMD_SIZE = 8;
    localparam int DEFAULT_LEN_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_RUN  = 2'd2
    } seq_state_t;

    function automatic logic [63:0] swap_bytes64(input logic [63:0] data);
        logic [63:0] result;
        for (int i = 0; i < 8; i++) begin
            result[i*8 +: 8] = data[(7-i)*8 +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/main_host_sequencer_skid.sv
// Two-entry 64-bit skid buffer; accepts a push and a pop in the same cycle so a
// stream passing through it keeps one word per cycle.
module stream_skid64 (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] in_data,
    input  logic        in_isReady,
    output logic        in_canReceive,
    output logic [63:0] out_data,
    output logic        out_isReady,
    input  logic        out_canReceive
);

    logic [63:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        push;
    logic        pop;

    assign in_canReceive = (count != 2'd2);
    assign out_isReady   = (count != 2'd0);
    assign out_data      = out_isReady ? mem[rd_ptr] : 64'd0;
    assign push          = in_isReady & in_canReceive;
    assign pop           = out_isReady & out_canReceive;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= 64'd0;
            mem[1] <= 64'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/main_host_sequencer.sv
// Host-side master for the main core: issues one command, then streams input
// words into main and main's output words to the host sink, concurrently.
module main_host_sequencer
    import main_host_sequencer_pkg::*;
#(
    parameter int CMD_W = MAIN_CMD_SIZE,
    parameter int LEN_W = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CMD_W-1:0] job_cmd,
    input  logic [LEN_W-1:0] job_inWords,
    input  logic [LEN_W-1:0] job_outWords,
    input  logic             job_swap,
    input  logic             job_isReady,
    output logic             job_canReceive,
    input  logic [63:0]      src,
    input  logic             src_isReady,
    output logic             src_canReceive,
    output logic [63:0]      dst,
    output logic             dst_isReady,
    input  logic             dst_canReceive,
    output logic [CMD_W-1:0] m_cmd,
    output logic             m_cmd_isReady,
    input  logic             m_cmd_canReceive,
    output logic [63:0]      m_in,
    output logic             m_in_isReady,
    input  logic             m_in_canReceive,
    input  logic [63:0]      m_out,
    input  logic             m_out_isReady,
    output logic             m_out_canReceive,
    output logic             busy,
    output logic             done
);

    seq_state_t       state;
    seq_state_t       next_state;
    logic [CMD_W-1:0] cmd_q;
    logic [LEN_W-1:0] in_cnt;
    logic [LEN_W-1:0] out_cnt;
    logic             swap_q;
    logic             in_skid_can;
    logic             out_skid_can;
    logic             job_fire;
    logic             src_fire;
    logic             m_out_fire;
    logic             run_done;

    assign job_fire   = job_isReady & job_canReceive;
    assign src_fire   = src_isReady & src_canReceive;
    assign m_out_fire = m_out_isReady & m_out_canReceive;
    assign run_done   = (in_cnt == '0) && (out_cnt == '0) && !m_in_isReady && !dst_isReady;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (job_fire)         next_state = ST_CMD;
            ST_CMD:  if (m_cmd_canReceive) next_state = ST_RUN;
            ST_RUN:  if (run_done)         next_state = ST_IDLE;
            default:                       next_state = ST_IDLE;
        endcase
    end

    // Stream ready signals depend only on state, counters and buffer fill,
    // never combinationally on the far side's canReceive.
    always_comb begin
        job_canReceive   = 1'b0;
        m_cmd            = '0;
        m_cmd_isReady    = 1'b0;
        src_canReceive   = 1'b0;
        m_out_canReceive = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        case (state)
            ST_IDLE: job_canReceive = rst;
            ST_CMD: begin
                m_cmd         = cmd_q;
                m_cmd_isReady = 1'b1;
                busy          = 1'b1;
            end
            ST_RUN: begin
                busy             = 1'b1;
                src_canReceive   = (in_cnt != '0) & in_skid_can;
                m_out_canReceive = (out_cnt != '0) & out_skid_can;
                done             = run_done;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q   <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
            swap_q  <= 1'b0;
        end else if (job_fire) begin
            cmd_q   <= job_cmd;
            in_cnt  <= job_inWords;
            out_cnt <= job_outWords;
            swap_q  <= job_swap;
        end else begin
            if (src_fire) begin
                in_cnt <= in_cnt - LEN_W'(1);
            end
            if (m_out_fire) begin
                out_cnt <= out_cnt - LEN_W'(1);
            end
        end
    end

    stream_skid64 u_in_skid (
        .clk            (clk),
        .rst            (rst),
        .in_data        (swap_q ? swap_bytes64(src) : src),
        .in_isReady     (src_fire),
        .in_canReceive  (in_skid_can),
        .out_data       (m_in),
        .out_isReady    (m_in_isReady),
        .out_canReceive (m_in_canReceive)
    );

    stream_skid64 u_out_skid (
        .clk            (clk),
        .rst            (rst),
        .in_data        (swap_q ? swap_bytes64(m_out) : m_out),
        .in_isReady     (m_out_fire),
        .in_canReceive  (out_skid_can),
        .out_data       (dst),
        .out_isReady    (dst_isReady),
        .out_canReceive (dst_canReceive)
    );

endmodule

// File: tb/tb_main_host_sequencer.sv
// Self-checking bench for main_host_sequencer: emulates the host source/sink and
// the main core, and compares every transfer against a queue-based reference.
module tb_main_host_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  job_cmd;
    logic [15:0] job_inWords;
    logic [15:0] job_outWords;
    logic        job_swap;
    logic        job_isReady;
    logic        job_canReceive;
    logic [63:0] src;
    logic        src_isReady;
    logic        src_canReceive;
    logic [63:0] dst;
    logic        dst_isReady;
    logic        dst_canReceive;
    logic [7:0]  m_cmd;
    logic        m_cmd_isReady;
    logic        m_cmd_canReceive;
    logic [63:0] m_in;
    logic        m_in_isReady;
    logic        m_in_canReceive;
    logic [63:0] m_out;
    logic        m_out_isReady;
    logic        m_out_canReceive;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic [63:0] src_words[$];
    logic [63:0] main_words[$];
    logic [63:0] exp_in[$];
    logic [63:0] exp_dst[$];
    logic [63:0] got_in[$];
    logic [63:0] got_dst[$];
    logic [7:0]  got_cmd;
    int n_cmd_cycles, n_cmd_fire, n_done, n_src_acc, n_mout_acc, stall_bad;
    int cmd_cycle, done_cycle, src_first_cycle, mout_first_cycle;
    int first_min_cycle, last_min_cycle, first_dst_cycle, last_dst_cycle;
    bit timed_out, aborted;

    always #5 clk = ~clk;

    main_host_sequencer #(.CMD_W(8), .LEN_W(16)) dut (
        .clk              (clk),
        .rst              (rst),
        .job_cmd          (job_cmd),
        .job_inWords      (job_inWords),
        .job_outWords     (job_outWords),
        .job_swap         (job_swap),
        .job_isReady      (job_isReady),
        .job_canReceive   (job_canReceive),
        .src              (src),
        .src_isReady      (src_isReady),
        .src_canReceive   (src_canReceive),
        .dst              (dst),
        .dst_isReady      (dst_isReady),
        .dst_canReceive   (dst_canReceive),
        .m_cmd            (m_cmd),
        .m_cmd_isReady    (m_cmd_isReady),
        .m_cmd_canReceive (m_cmd_canReceive),
        .m_in             (m_in),
        .m_in_isReady     (m_in_isReady),
        .m_in_canReceive  (m_in_canReceive),
        .m_out            (m_out),
        .m_out_isReady    (m_out_isReady),
        .m_out_canReceive (m_out_canReceive),
        .busy             (busy),
        .done             (done)
    );

    function automatic logic [63:0] ref_swap(input logic [63:0] w, input logic sw);
        logic [63:0] r;
        r = {<<8{w}};
        return sw ? r : w;
    endfunction

    function automatic int first_diff(input logic [63:0] a[$], input logic [63:0] b[$]);
        if (a.size() != b.size()) return 0;
        foreach (a[i]) if (a[i] !== b[i]) return i;
        return -1;
    endfunction

    task automatic fill_random(input int n_src, input int n_main);
        src_words.delete();
        main_words.delete();
        for (int i = 0; i < n_src; i++) src_words.push_back({$urandom, $urandom});
        for (int i = 0; i < n_main; i++) main_words.push_back({$urandom, $urandom});
    endtask

    // Host + main emulation: inputs change on negedge, handshakes observed 1ns later.
    task automatic run_job(input logic [7:0] cmd, input int n_in, input int n_out, input logic sw,
                           input bit bp, input bit out_after_in, input int abort_after);
        int  src_idx, main_idx, post;
        bit  src_took, mout_took, done_seen, min_stall, dst_stall;
        logic [63:0] min_hold, dst_hold;
        src_idx = 0; main_idx = 0; post = 0;
        src_took = 0; mout_took = 0; done_seen = 0; min_stall = 0; dst_stall = 0;
        min_hold = '0; dst_hold = '0;
        got_in.delete(); got_dst.delete(); exp_in.delete(); exp_dst.delete();
        n_cmd_cycles = 0; n_cmd_fire = 0; n_done = 0; n_src_acc = 0; n_mout_acc = 0; stall_bad = 0;
        cmd_cycle = -1; done_cycle = -1; src_first_cycle = -1; mout_first_cycle = -1;
        first_min_cycle = -1; last_min_cycle = -1; first_dst_cycle = -1; last_dst_cycle = -1;
        got_cmd = '0; timed_out = 0; aborted = 0;
        for (int i = 0; i < n_in; i++) exp_in.push_back(ref_swap(src_words[i], sw));
        for (int i = 0; i < n_out; i++) exp_dst.push_back(ref_swap(main_words[i], sw));
        @(negedge clk);
        job_cmd = cmd; job_inWords = 16'(n_in); job_outWords = 16'(n_out);
        job_swap = sw; job_isReady = 1'b1;
        @(posedge clk);
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clk);
            job_isReady = 1'b0;
            if (abort_after >= 0 && n_src_acc == abort_after) begin
                rst = 1'b0;
                aborted = 1;
                break;
            end
            if (src_took) begin src_idx++; src_isReady = 1'b0; end
            if (!src_isReady && src_idx < src_words.size() && (!bp || $urandom_range(3) != 0)) begin
                src = src_words[src_idx];
                src_isReady = 1'b1;
            end
            if (mout_took) begin main_idx++; m_out_isReady = 1'b0; end
            if (!m_out_isReady && main_idx < main_words.size() && (!out_after_in || got_in.size() >= n_in)
                && (!bp || $urandom_range(2) != 0)) begin
                m_out = main_words[main_idx];
                m_out_isReady = 1'b1;
            end
            m_cmd_canReceive = !bp || ($urandom_range(1) == 1);
            m_in_canReceive  = !bp || ($urandom_range(1) == 1);
            dst_canReceive   = !bp || ($urandom_range(1) == 1);
            #1;
            src_took = (src_isReady & src_canReceive) === 1'b1;
            if (src_took) begin
                if (src_first_cycle < 0) src_first_cycle = cyc;
                n_src_acc++;
            end
            mout_took = (m_out_isReady & m_out_canReceive) === 1'b1;
            if (mout_took) begin
                if (mout_first_cycle < 0) mout_first_cycle = cyc;
                n_mout_acc++;
            end
            if (m_cmd_isReady === 1'b1) n_cmd_cycles++;
            if ((m_cmd_isReady & m_cmd_canReceive) === 1'b1) begin
                n_cmd_fire++; got_cmd = m_cmd; cmd_cycle = cyc;
            end
            if (min_stall && (m_in_isReady !== 1'b1 || m_in !== min_hold)) stall_bad++;
            if ((m_in_isReady & m_in_canReceive) === 1'b1) begin
                got_in.push_back(m_in);
                if (first_min_cycle < 0) first_min_cycle = cyc;
                last_min_cycle = cyc;
            end
            min_stall = (m_in_isReady === 1'b1) && (m_in_canReceive !== 1'b1);
            min_hold  = m_in;
            if (dst_stall && (dst_isReady !== 1'b1 || dst !== dst_hold)) stall_bad++;
            if ((dst_isReady & dst_canReceive) === 1'b1) begin
                got_dst.push_back(dst);
                if (first_dst_cycle < 0) first_dst_cycle = cyc;
                last_dst_cycle = cyc;
            end
            dst_stall = (dst_isReady === 1'b1) && (dst_canReceive !== 1'b1);
            dst_hold  = dst;
            if (done === 1'b1) begin
                n_done++;
                if (!done_seen) done_cycle = cyc;
                done_seen = 1;
            end else if (done_seen) begin
                post++;
                if (post >= 3) break;
            end
        end
        timed_out = !done_seen && !aborted;
        src_isReady = 1'b0;
        m_out_isReady = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        job_cmd = '0; job_inWords = '0; job_outWords = '0; job_swap = 1'b0; job_isReady = 1'b0;
        src = '0; src_isReady = 1'b0; dst_canReceive = 1'b0; m_cmd_canReceive = 1'b0;
        m_in_canReceive = 1'b0; m_out = '0; m_out_isReady = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({m_cmd_isReady, m_in_isReady, dst_isReady, src_canReceive, m_out_canReceive, busy, done} !== 7'd0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b want 0000000",
                     {m_cmd_isReady, m_in_isReady, dst_isReady, src_canReceive, m_out_canReceive, busy, done});
        end
        checks++;
        if (m_cmd !== 8'd0 || dst !== 64'd0) begin
            errors++; $display("[TB] FAIL reset_data: m_cmd=%h dst=%h want 0", m_cmd, dst);
        end
        checks++;
        if (job_canReceive !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_job_can_in_reset: got %b want 0", job_canReceive);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (job_canReceive !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_job_can_after: got %b want 1", job_canReceive);
        end
    endtask

    task automatic test_set_param();
        fill_random(1, 1);
        run_job(8'h21, 0, 0, 1'b0, 0, 0, -1);
        checks++;
        if (timed_out || n_done !== 1) begin
            errors++; $display("[TB] FAIL setparam_done_count: got %0d want 1", n_done);
        end
        checks++;
        if (n_cmd_cycles !== 1 || got_cmd !== 8'h21) begin
            errors++; $display("[TB] FAIL setparam_cmd: cycles=%0d cmd=%h want 1 / 21", n_cmd_cycles, got_cmd);
        end
        checks++;
        if (done_cycle !== cmd_cycle + 1) begin
            errors++; $display("[TB] FAIL setparam_done_latency: got %0d want %0d", done_cycle, cmd_cycle + 1);
        end
        checks++;
        if (n_src_acc !== 0 || n_mout_acc !== 0 || got_in.size() !== 0 || got_dst.size() !== 0) begin
            errors++; $display("[TB] FAIL setparam_no_data: src=%0d mout=%0d want 0/0", n_src_acc, n_mout_acc);
        end
    endtask

    task automatic test_swap();
        src_words.delete(); main_words.delete();
        src_words.push_back(64'h0102030405060708);
        main_words.push_back(64'hAABBCCDDEEFF0011);
        run_job(8'h05, 1, 1, 1'b1, 0, 0, -1);
        checks++;
        if (got_in.size() !== 1 || got_in[0] !== 64'h0807060504030201) begin
            errors++; $display("[TB] FAIL swap_in: got %h want 0807060504030201", got_in.size() ? got_in[0] : 64'd0);
        end
        checks++;
        if (first_min_cycle !== src_first_cycle + 1) begin
            errors++; $display("[TB] FAIL swap_in_latency: got %0d want %0d", first_min_cycle, src_first_cycle + 1);
        end
        checks++;
        if (got_dst.size() !== 1 || got_dst[0] !== 64'h1100FFEEDDCCBBAA) begin
            errors++; $display("[TB] FAIL swap_out: got %h want 1100ffeeddccbbaa", got_dst.size() ? got_dst[0] : 64'd0);
        end
        checks++;
        if (first_dst_cycle !== mout_first_cycle + 1 || n_done !== 1) begin
            errors++; $display("[TB] FAIL swap_out_latency: got %0d want %0d", first_dst_cycle, mout_first_cycle + 1);
        end
    endtask

    task automatic test_decaps();
        fill_random(3705, 2);
        run_job(8'h33, 3705, 2, 1'b0, 0, 1, -1);
        checks++;
        if (timed_out || got_in.size() !== 3705 || first_diff(got_in, exp_in) != -1) begin
            errors++; $display("[TB] FAIL decaps_in_data: got %0d words (diff at %0d) want 3705",
                               got_in.size(), first_diff(got_in, exp_in));
        end
        checks++;
        if (last_min_cycle - first_min_cycle !== 3704) begin
            errors++; $display("[TB] FAIL decaps_in_burst: got span %0d want 3704", last_min_cycle - first_min_cycle);
        end
        checks++;
        if (got_dst.size() !== 2 || first_diff(got_dst, exp_dst) != -1 || first_dst_cycle <= last_min_cycle) begin
            errors++; $display("[TB] FAIL decaps_out: got %0d words first at %0d want 2 after %0d",
                               got_dst.size(), first_dst_cycle, last_min_cycle);
        end
        checks++;
        if (n_done !== 1 || done_cycle <= last_dst_cycle) begin
            errors++; $display("[TB] FAIL decaps_done: got %0d at %0d want 1 after %0d", n_done, done_cycle, last_dst_cycle);
        end
    endtask

    task automatic test_backpressure();
        for (int pass = 0; pass < 3; pass++) begin
            logic sw;
            int n_in, n_out;
            sw = 1'($urandom_range(1));
            n_in = 20 + $urandom_range(30);
            n_out = 10 + $urandom_range(30);
            fill_random(n_in, n_out);
            run_job(8'($urandom), n_in, n_out, sw, 1, 0, -1);
            checks++;
            if (timed_out || got_in.size() !== n_in || first_diff(got_in, exp_in) != -1) begin
                errors++; $display("[TB] FAIL bp_in_data[%0d]: got %0d words (diff %0d) want %0d",
                                   pass, got_in.size(), first_diff(got_in, exp_in), n_in);
            end
            checks++;
            if (got_dst.size() !== n_out || first_diff(got_dst, exp_dst) != -1) begin
                errors++; $display("[TB] FAIL bp_out_data[%0d]: got %0d words (diff %0d) want %0d",
                                   pass, got_dst.size(), first_diff(got_dst, exp_dst), n_out);
            end
            checks++;
            if (stall_bad !== 0 || n_cmd_fire !== 1 || n_done !== 1) begin
                errors++; $display("[TB] FAIL bp_protocol[%0d]: stall=%0d cmd=%0d done=%0d want 0/1/1",
                                   pass, stall_bad, n_cmd_fire, n_done);
            end
        end
    endtask

    task automatic test_oversupply();
        fill_random(3, 3);
        run_job(8'h44, 3, 2, 1'b1, 0, 0, -1);
        checks++;
        if (n_mout_acc !== 2 || got_dst.size() !== 2 || first_diff(got_dst, exp_dst) != -1) begin
            errors++; $display("[TB] FAIL oversupply_accepts: got %0d want 2", n_mout_acc);
        end
        checks++;
        if (busy !== 1'b0 || job_canReceive !== 1'b1 || n_done !== 1) begin
            errors++; $display("[TB] FAIL oversupply_idle: busy=%b jobcan=%b done=%0d want 0/1/1",
                               busy, job_canReceive, n_done);
        end
    endtask

    task automatic test_reset_mid_run();
        logic sw;
        fill_random(200, 5);
        run_job(8'h55, 200, 5, 1'b0, 0, 0, 100);
        #1;
        checks++;
        if (!aborted || {m_cmd_isReady, m_in_isReady, dst_isReady, src_canReceive, m_out_canReceive, busy} !== 6'd0) begin
            errors++; $display("[TB] FAIL abort_flags: got %b want 000000",
                               {m_cmd_isReady, m_in_isReady, dst_isReady, src_canReceive, m_out_canReceive, busy});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (job_canReceive !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL abort_release: jobcan=%b busy=%b want 1/0", job_canReceive, busy);
        end
        sw = 1'b1;
        fill_random(12, 7);
        run_job(8'h66, 12, 7, sw, 1, 0, -1);
        checks++;
        if (timed_out || first_diff(got_in, exp_in) != -1 || first_diff(got_dst, exp_dst) != -1 || n_done !== 1) begin
            errors++; $display("[TB] FAIL abort_fresh_job: in=%0d out=%0d done=%0d want 12/7/1",
                               got_in.size(), got_dst.size(), n_done);
        end
    endtask

    initial begin
        test_reset();
        test_set_param();
        test_swap();
        test_decaps();
        test_backpressure();
        test_oversupply();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
